// File: rtl/msrv32_alu_issue.sv
// msrv32 ALU issue stage: decodes OP/OP-IMM/LUI/AUIPC into ALU
// operand/opcode bundles and holds them in a 2-entry issue buffer.
module msrv32_alu_issue #(
  parameter int DEPTH = 2
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_n_in,
  input  logic        flush_in,
  input  logic        valid_in,
  output logic        ready_out,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] rs1_data_in,
  input  logic [31:0] rs2_data_in,
  output logic        alu_valid_out,
  input  logic        alu_ready_in,
  output logic [31:0] op_1_out,
  output logic [31:0] op_2_out,
  output logic [3:0]  opcode_out,
  output logic [4:0]  rd_out,
  output logic        illegal_out
);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] F7_ZERO   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  logic [6:0]  w_opc7;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic        w_f3_add;
  logic        w_f3_sr;
  logic        w_f3_sh;
  logic        w_f7_ok;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_u;

  logic [31:0] w_op1;
  logic [31:0] w_op2;
  logic [3:0]  w_opc;
  logic        w_ill;

  logic        w_push;
  logic        w_pop;

  logic [31:0] r_op1 [DEPTH];
  logic [31:0] r_op2 [DEPTH];
  logic [3:0]  r_opc [DEPTH];
  logic [4:0]  r_rd  [DEPTH];
  logic        r_ill [DEPTH];
  logic [1:0]  r_cnt;
  logic        r_wp;
  logic        r_rp;

  assign w_opc7   = instr_in[6:0];
  assign w_f3     = instr_in[14:12];
  assign w_f7     = instr_in[31:25];
  assign w_f3_add = (w_f3 == 3'b000);
  assign w_f3_sr  = (w_f3 == 3'b101);
  assign w_f3_sh  = (w_f3 == 3'b001) || w_f3_sr;
  assign w_imm_i  = {{20{instr_in[31]}}, instr_in[31:20]};
  assign w_imm_u  = {instr_in[31:12], 12'b0};

  // alt funct7 is only meaningful for SUB/SRA (OP) and SRAI (OP-IMM)
  always_comb begin
    w_f7_ok = 1'b0;
    unique case (1'b1)
      (w_f7 == F7_ZERO): w_f7_ok = 1'b1;
      (w_f7 == F7_ALT):  w_f7_ok = w_f3_sr ||
                                   (w_f3_add && w_opc7 == OPC_OP);
      default:           w_f7_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_op1 = 32'b0;
    w_op2 = 32'b0;
    w_opc = 4'b0;
    w_ill = 1'b0;
    unique case (1'b1)
      (w_opc7 == OPC_OP): begin
        w_op1 = rs1_data_in;
        w_op2 = rs2_data_in;
        w_opc = {instr_in[30], w_f3};
        w_ill = !w_f7_ok;
      end
      (w_opc7 == OPC_OPIMM): begin
        w_op1 = rs1_data_in;
        if (w_f3_sh) begin
          w_op2 = {27'b0, instr_in[24:20]};
          w_opc = {w_f3_sr & instr_in[30], w_f3};
          w_ill = !w_f7_ok;
        end else begin
          w_op2 = w_imm_i;
          w_opc = {1'b0, w_f3};
        end
      end
      (w_opc7 == OPC_LUI): begin
        w_op2 = w_imm_u;
      end
      (w_opc7 == OPC_AUIPC): begin
        w_op1 = pc_in;
        w_op2 = w_imm_u;
      end
      default: w_ill = 1'b1;
    endcase
    if (w_ill) begin
      w_op1 = 32'b0;
      w_op2 = 32'b0;
      w_opc = 4'b0;
    end
  end

  assign ready_out     = (r_cnt != 2'd2);
  assign alu_valid_out = (r_cnt != 2'd0);
  assign w_push        = valid_in && ready_out;
  assign w_pop         = alu_valid_out && alu_ready_in;

  assign op_1_out    = r_op1[r_rp];
  assign op_2_out    = r_op2[r_rp];
  assign opcode_out  = r_opc[r_rp];
  assign rd_out      = r_rd[r_rp];
  assign illegal_out = r_ill[r_rp];

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_op1[i] <= 32'b0;
        r_op2[i] <= 32'b0;
        r_opc[i] <= 4'b0;
        r_rd[i]  <= 5'b0;
        r_ill[i] <= 1'b0;
      end
      r_cnt <= 2'd0;
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
    end else if (flush_in) begin
      r_cnt <= 2'd0;
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
    end else begin
      if (w_push) begin
        r_op1[r_wp] <= w_op1;
        r_op2[r_wp] <= w_op2;
        r_opc[r_wp] <= w_opc;
        r_rd[r_wp]  <= instr_in[11:7];
        r_ill[r_wp] <= w_ill;
        r_wp        <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_msrv32_alu_issue.sv
// Directed self-checking bench for msrv32_alu_issue.
// Outputs are sampled on the falling edge; inputs change #1 after rising.
module tb_msrv32_alu_issue;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        valid;
  logic        ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        avalid;
  logic        aready;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [3:0]  opc;
  logic [4:0]  rd;
  logic        ill;

  int n_chk;
  int n_fail;

  msrv32_alu_issue #(.DEPTH(2)) dut (
    .ms_riscv32_mp_clk_in   (clk),
    .ms_riscv32_mp_rst_n_in (rst_n),
    .flush_in               (flush),
    .valid_in               (valid),
    .ready_out              (ready),
    .instr_in               (instr),
    .pc_in                  (pc),
    .rs1_data_in            (rs1),
    .rs2_data_in            (rs2),
    .alu_valid_out          (avalid),
    .alu_ready_in           (aready),
    .op_1_out               (op1),
    .op_2_out               (op2),
    .opcode_out             (opc),
    .rd_out                 (rd),
    .illegal_out            (ill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] i,
                       input logic [31:0] p,
                       input logic [31:0] a,
                       input logic [31:0] b);
    instr = i;
    pc    = p;
    rs1   = a;
    rs2   = b;
  endtask

  // one-cycle push; caller guarantees room in the buffer
  task automatic push(input logic [31:0] i,
                      input logic [31:0] p,
                      input logic [31:0] a,
                      input logic [31:0] b);
    drive(i, p, a, b);
    valid = 1'b1;
    @(posedge clk);
    #1 valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic pop();
    aready = 1'b1;
    @(posedge clk);
    #1 aready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    flush  = 1'b0;
    valid  = 1'b0;
    aready = 1'b0;
    drive(32'h0, 32'h0, 32'h0, 32'h0);

    // reset state, with a push attempt that must be ignored
    valid = 1'b1;
    drive(32'h002081B3, 32'h0, 32'd5, 32'd7);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(avalid), 32'd0);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_op1", op1, 32'h0);
    chk("rst_op2", op2, 32'h0);
    chk("rst_opc", 32'(opc), 32'h0);
    chk("rst_rd", 32'(rd), 32'h0);
    chk("rst_ill", 32'(ill), 32'h0);
    valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_empty", 32'(avalid), 32'd0);

    // ADD x3,x1,x2 / SUB x3,x1,x2
    push(32'h002081B3, 32'h0, 32'd5, 32'd7);
    chk("add_valid", 32'(avalid), 32'd1);
    chk("add_op1", op1, 32'd5);
    chk("add_op2", op2, 32'd7);
    chk("add_opc", 32'(opc), 32'h0);
    chk("add_rd", 32'(rd), 32'd3);
    chk("add_ill", 32'(ill), 32'd0);
    pop();
    chk("pop_empty", 32'(avalid), 32'd0);
    push(32'h402081B3, 32'h0, 32'd5, 32'd7);
    chk("sub_opc", 32'(opc), 32'h8);
    chk("sub_ill", 32'(ill), 32'd0);
    pop();

    // SRAI x1,x1,3 and ADDI x1,x0,-1
    push(32'h4030D093, 32'h0, 32'h8000_0000, 32'h0);
    chk("srai_op1", op1, 32'h8000_0000);
    chk("srai_op2", op2, 32'd3);
    chk("srai_opc", 32'(opc), 32'hD);
    chk("srai_ill", 32'(ill), 32'd0);
    pop();
    push(32'hFFF00093, 32'h0, 32'd0, 32'd9);
    chk("addi_op2", op2, 32'hFFFF_FFFF);
    chk("addi_opc", 32'(opc), 32'h0);
    pop();

    // alt funct7 outside SUB/SRA(I) is illegal
    push(32'h40109093, 32'h0, 32'd1, 32'd1);
    chk("slli_alt_ill", 32'(ill), 32'd1);
    chk("slli_alt_op2", op2, 32'h0);
    pop();
    push(32'h402091B3, 32'h0, 32'd1, 32'd1);
    chk("sll_alt_ill", 32'(ill), 32'd1);
    chk("sll_alt_rd", 32'(rd), 32'd3);
    pop();

    // LUI x5 / AUIPC x5
    push(32'h123452B7, 32'h0, 32'h55, 32'h66);
    chk("lui_op1", op1, 32'h0);
    chk("lui_op2", op2, 32'h1234_5000);
    chk("lui_rd", 32'(rd), 32'd5);
    chk("lui_opc", 32'(opc), 32'h0);
    pop();
    push(32'h12345297, 32'h100, 32'h55, 32'h66);
    chk("auipc_op1", op1, 32'h100);
    chk("auipc_op2", op2, 32'h1234_5000);
    pop();

    // unknown major opcode
    push(32'h0000007F, 32'h40, 32'd9, 32'd9);
    chk("bad_ill", 32'(ill), 32'd1);
    chk("bad_opc", 32'(opc), 32'h0);
    chk("bad_op1", op1, 32'h0);
    pop();

    // backpressure: A, B buffered, C held upstream, then drained in order
    aready = 1'b0;
    valid  = 1'b1;
    drive(32'h00100093, 32'h0, 32'd0, 32'd0);
    @(posedge clk);
    #1 drive(32'h00200093, 32'h0, 32'd0, 32'd0);
    @(negedge clk);
    chk("bp_ready1", 32'(ready), 32'd1);
    chk("bp_headA", op2, 32'd1);
    @(posedge clk);
    #1 drive(32'h00300093, 32'h0, 32'd0, 32'd0);
    @(negedge clk);
    chk("bp_ready_drop", 32'(ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("bp_hold_ready", 32'(ready), 32'd0);
    chk("bp_stableA", op2, 32'd1);
    aready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_headB", op2, 32'd2);
    chk("bp_ready_back", 32'(ready), 32'd1);
    @(posedge clk);
    #1 valid = 1'b0;
    @(negedge clk);
    chk("bp_headC", op2, 32'd3);
    chk("bp_validC", 32'(avalid), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("bp_drained", 32'(avalid), 32'd0);
    aready = 1'b0;

    // flush at count 2 with a push attempt
    push(32'h00100093, 32'h0, 32'd0, 32'd0);
    push(32'h00200093, 32'h0, 32'd0, 32'd0);
    chk("fl_full", 32'(ready), 32'd0);
    flush = 1'b1;
    valid = 1'b1;
    drive(32'h00300093, 32'h0, 32'd0, 32'd0);
    @(posedge clk);
    #1 begin
      flush = 1'b0;
      valid = 1'b0;
    end
    @(negedge clk);
    chk("fl2_valid", 32'(avalid), 32'd0);
    chk("fl2_ready", 32'(ready), 32'd1);

    // flush at count 1 discards an accepted-looking push
    push(32'h00100093, 32'h0, 32'd0, 32'd0);
    flush = 1'b1;
    valid = 1'b1;
    drive(32'h00200093, 32'h0, 32'd0, 32'd0);
    aready = 1'b1;
    @(posedge clk);
    #1 begin
      flush  = 1'b0;
      valid  = 1'b0;
      aready = 1'b0;
    end
    @(negedge clk);
    chk("fl1_valid", 32'(avalid), 32'd0);
    push(32'h00400093, 32'h0, 32'd0, 32'd0);
    chk("fl_then_push", op2, 32'd4);
    pop();
    chk("fl_then_pop", 32'(avalid), 32'd0);

    // back-to-back stream with ALU always ready
    aready = 1'b1;
    valid  = 1'b1;
    drive(32'h00500093, 32'h0, 32'd0, 32'd0);
    @(posedge clk);
    #1 drive(32'h00600093, 32'h0, 32'd0, 32'd0);
    @(negedge clk);
    chk("tp_5", op2, 32'd5);
    @(posedge clk);
    #1 drive(32'h00700093, 32'h0, 32'd0, 32'd0);
    @(negedge clk);
    chk("tp_6", op2, 32'd6);
    chk("tp_ready", 32'(ready), 32'd1);
    @(posedge clk);
    #1 valid = 1'b0;
    @(negedge clk);
    chk("tp_7", op2, 32'd7);
    @(posedge clk);
    @(negedge clk);
    chk("tp_empty", 32'(avalid), 32'd0);
    aready = 1'b0;

    // asynchronous reset with 2 entries buffered
    push(32'h002081B3, 32'h0, 32'd5, 32'd7);
    push(32'h402081B3, 32'h0, 32'd5, 32'd7);
    chk("ar_pre_valid", 32'(avalid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(avalid), 32'd0);
    chk("ar_ready", 32'(ready), 32'd1);
    chk("ar_op1", op1, 32'h0);
    chk("ar_op2", op2, 32'h0);
    chk("ar_rd", 32'(rd), 32'h0);
    chk("ar_ill", 32'(ill), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ar_post_empty", 32'(avalid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
